// File: rtl/freq_mon_pkg.sv
// ---------------------------------------------------------------------------
// freq_mon_pkg
// Shared definitions for freq_ratio_monitor:
//   state_e          - measurement FSM states (IDLE, MEAS)
//   DEF_CNT_W        - default period/high-time counter width
//   DEF_LOCK_CNT     - default number of good periods needed for lock
//   in_tol()         - |meas - exp| <= tol, evaluated without wrap-around
// ---------------------------------------------------------------------------
package freq_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_LOCK_CNT = 4;

    // Operands are zero-extended to 32 bits and differenced at 33 bits signed,
    // so the absolute deviation can never wrap for any counter width <= 32.
    function automatic logic in_tol(input logic [31:0] meas,
                                    input logic [31:0] exp_val,
                                    input logic [31:0] tol);
        logic signed [32:0] diff;
        diff = $signed({1'b0, meas}) - $signed({1'b0, exp_val});
        if (diff < 0) begin
            diff = -diff;
        end
        return (diff <= $signed({1'b0, tol}));
    endfunction

endpackage

// File: rtl/freq_ratio_monitor_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit, both flops cleared by
// reset.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   d_i  in  asynchronous input
//   q_o  out synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/freq_ratio_monitor.sv
// ---------------------------------------------------------------------------
// freq_ratio_monitor
// Measures the rise-to-rise period and high time of sig_in in clk cycles and
// checks the period against exp_period, reporting lock, mismatch and timeout.
//   clk         in  system clock, posedge
//   rst         in  synchronous active-high reset
//   sig_in      in  monitored signal, asynchronous to clk
//   exp_period  in  expected period in clk cycles (quasi-static)
//   period      out last measured period
//   high_time   out clk samples high within that period
//   meas_valid  out one-cycle pulse when period/high_time update
//   mismatch    out one-cycle pulse with meas_valid when out of tolerance
//   locked      out LOCK_CNT consecutive in-tolerance periods seen
//   timeout     out one-cycle pulse, no rise for 2^CNT_W-1 cycles
// ---------------------------------------------------------------------------
module freq_ratio_monitor
    import freq_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int TOL      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             mismatch,
    output logic             locked,
    output logic             timeout
);

    localparam int              MW      = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]   LOCK_M  = MW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s2;
    logic             s_d_q;
    logic             rise;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hcnt_q,   hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic [MW-1:0]    match_q,  match_d;
    logic             mv_q,     mv_d;
    logic             mis_q,    mis_d;
    logic             lock_q,   lock_d;
    logic             to_q,     to_d;
    logic             tol_ok;

    // Input synchronization and edge detect
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sig_in),
        .q_o (s2)
    );

    assign rise = s2 & ~s_d_q;

    // Measurement FSM, counters, tolerance and lock tracking
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        match_d  = match_q;
        mv_d     = 1'b0;
        mis_d    = 1'b0;
        to_d     = 1'b0;

        tol_ok = in_tol(32'(cnt_q), 32'(exp_period), 32'(TOL));

        case (state_q)
            IDLE: begin
                // First rise only establishes the reference edge.
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                    state_d = MEAS;
                end
            end
            MEAS: begin
                // A rise on the all-ones count still measures; timeout only
                // fires when the counter would otherwise have to wrap.
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    mv_d     = 1'b1;
                    cnt_d    = CNT_ONE;
                    hcnt_d   = CNT_ONE;
                    if (tol_ok) begin
                        match_d = (match_q == LOCK_M) ? LOCK_M : match_q + 1'b1;
                    end else begin
                        match_d = '0;
                        mis_d   = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    to_d    = 1'b1;
                    match_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    hcnt_d = hcnt_q + CNT_W'(s2);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        lock_d = (match_d == LOCK_M);
    end

    // Output/state register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            match_q  <= '0;
            mv_q     <= 1'b0;
            mis_q    <= 1'b0;
            lock_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            s_d_q    <= s2;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            match_q  <= match_d;
            mv_q     <= mv_d;
            mis_q    <= mis_d;
            lock_q   <= lock_d;
            to_q     <= to_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign mismatch   = mis_q;
    assign locked     = lock_q;
    assign timeout    = to_q;

endmodule

// File: doc/freq_ratio_monitor.md
# freq_ratio_monitor

Measures an incoming divided clock or strobe (`sig_in`) in units of `clk` cycles and reports its period and high time. It also flags lock, mismatch and timeout against an expected period. It is the receive-side checker for the clock-divider blocks: it confirms that a divided output actually toggles at the programmed ratio before downstream logic consumes it.

## Interface
Parameters:
- `CNT_W`, 8: width of the period and high-time counters.
- `LOCK_CNT`, 4: number of consecutive in-tolerance periods required to assert `locked`.
- `TOL`, 0: allowed absolute deviation, in `clk` cycles, of the measured period from `exp_period`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous active-high reset.
- `sig_in`  in  1  monitored signal; asynchronous to `clk`.
- `exp_period`  in  CNT_W  expected period in `clk` cycles; quasi-static.
- `period`  out  CNT_W  last measured rise-to-rise period.
- `high_time`  out  CNT_W  number of `clk` samples high within that period.
- `meas_valid`  out  1  one-cycle pulse; `period` and `high_time` updated.
- `mismatch`  out  1  one-cycle pulse with `meas_valid` when the period is out of tolerance.
- `locked`  out  1  level; `LOCK_CNT` consecutive in-tolerance periods seen.
- `timeout`  out  1  one-cycle pulse; no rise detected for 2^CNT_W−1 cycles.

## Operation
- **Input path:** `sig_in` → 2-flop synchronizer (`s2`) → delay flop `s_d`. `rise = s2 & ~s_d`.
- **States:** IDLE (no reference edge yet) and MEAS (reference edge captured).
- **IDLE:**
  - On `rise`: `cnt`←1, `hcnt`←1, go to MEAS.
  - No measurement is reported.
- **MEAS, no `rise`:**
  - `cnt`←`cnt`+1.
  - `hcnt`←`hcnt`+`s2`.
- **MEAS, `rise`:**
  - `period`←`cnt`, `high_time`←`hcnt`, `meas_valid`←1.
  - `cnt`←1, `hcnt`←1.
- **Tolerance check on each measurement:** the period is in tolerance when |`cnt`−`exp_period`| ≤ `TOL`, computed at CNT_W+1 bits with no wrap.
  - In tolerance: `match_cnt`←min(`match_cnt`+1, `LOCK_CNT`).
  - Out of tolerance: `match_cnt`←0, `mismatch`←1.
  - `locked` = (`match_cnt` == `LOCK_CNT`), registered.
- **Timeout:** in MEAS, when `cnt` == all-ones and there is no `rise`:
  - `timeout`←1, `match_cnt`←0, `locked`←0, go to IDLE.
  - `cnt` never wraps.
- **Simultaneous events:**
  - `rise` in the same cycle `cnt` hits all-ones: the rise wins. The measurement is reported with `period` = all-ones and no timeout.
  - `rst` has priority over everything.
- **Reset (including mid-operation):**
  - Synchronizer flops, `s_d`, `cnt`, `hcnt`, `period`, `high_time` and `match_cnt` clear to 0.
  - `meas_valid`, `mismatch`, `locked` and `timeout` clear to 0; state goes to IDLE.
  - The first rise after reset is a reference edge only.
- **`exp_period` changes:** take effect at the next measurement. `locked` stays as-is until that measurement.
- **`high_time` resolution:** sampled on posedge only, so a signal with a half-cycle high time (e.g. a 50 % duty divide-by-3) reads as either rounding. `high_time` is informational and is not checked.

## Timing
- `sig_in` sampled high first at posedge k ⇒ `rise` is true during cycle k+1 ⇒ outputs update at posedge k+2.
- `meas_valid` and `mismatch` are high for exactly one cycle after posedge k+2.
- `locked` asserts at the same posedge as the `LOCK_CNT`-th consecutive good `meas_valid`.
- `locked` deasserts at the same posedge as a `mismatch` or `timeout`.
- `timeout` asserts 2^CNT_W−1 cycles after the last counted rise (255 for CNT_W=8).
- Minimum measurable period is 2 cycles: `sig_in` must be low for at least one sample between rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `freq_mon_pkg`:
  - State enum {IDLE, MEAS}.
  - Default `CNT_W`/`LOCK_CNT` constants.
  - Function `in_tol(meas, exp, tol)`.
- Sub-module `sync_2ff` (1-bit, reset to 0), instantiated for `sig_in`.
- The rest is flat: counters, tolerance compare, lock counter and state register.

## Test plan
- Period-3 square wave, `exp_period`=3, `TOL`=0:
  - The first rise gives no `meas_valid`.
  - Each subsequent rise gives `period`=3.
  - `locked`=1 on the 4th `meas_valid`; no `mismatch`.
- Period-4 wave, `exp_period`=3: `mismatch` with every `meas_valid`, `locked` never asserts.
- Same period-4 wave, rebuilt with `TOL`=1: lock after 4 periods.
- Lock on period 3, then hold `sig_in` low:
  - `timeout` pulses 255 cycles after the last rise.
  - `locked` falls on the same edge; state returns to IDLE.
  - The next rise yields no `meas_valid`.
- Lock on period 5, high 2, then assert `rst` for 1 cycle mid-period:
  - All outputs read 0 the cycle after.
  - Relock requires 1 reference rise plus 4 good periods.
- One period of 6 injected into a locked period-3 stream: exactly one `mismatch` pulse; `locked` drops and reasserts after 4 more good periods.
